instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: owns the program counter, drives the memory address and captures the returned instruction.
- Presents each instruction with its PC to decode through a valid/ready handshake.
- Handles stalls, branch redirects and halt.
- Sits between the instruction memory (combinational read: the address is applied and the instruction is valid in the same cycle) and the decode stage.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address (byte address).
- INSTR_WIDTH, 32, width of the instruction word.
- RESET_PC, 0, PC value loaded on reset (must be a multiple of 4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- imem_address  output  ADDR_WIDTH  address driven to the instruction memory; always equals pc.
- imem_instruction  input  INSTR_WIDTH  instruction returned by the memory for imem_address, same cycle.
- out_valid  output  1  fetch register holds a valid instruction.
- out_ready  input  1  decode accepts the instruction this cycle.
- out_instruction  output  INSTR_WIDTH  fetched instruction (registered).
- out_pc  output  ADDR_WIDTH  address the instruction was fetched from (registered).
- redirect_valid  input  1  branch/jump taken; load redirect_target.
- redirect_target  input  ADDR_WIDTH  new PC.
- halt_req  input  1  stop fetching.
- halted  output  1  block is in the HALT state.
- misalign_fault  output  1  sticky; only present with IFU_MISALIGN_TRAP_EN.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc=RESET_PC, state=FETCH.
  - out_valid=0, out_instruction=0, out_pc=0.
  - halted=0, misalign_fault=0.
- States:
  - FETCH: normal operation.
  - HALT: no fetching; halted=1.
- Definition: accept = out_valid & out_ready.
  - Decode must hold out_ready independent of out_valid.
  - The fetch unit never drops out_valid without an accept, except on redirect or halt flush.
- FETCH, evaluated each cycle in priority order:
  1. redirect_valid=1:
     - out_valid <= 0 (flush).
     - pc <= redirect_target.
     - A redirect in the same cycle as an accept still flushes; decode has consumed the old word.
  2. halt_req=1:
     - state <= HALT, out_valid <= 0.
     - pc is unchanged and points at the next unfetched word.
  3. Load condition (out_valid=0 or accept):
     - out_instruction <= imem_instruction, out_pc <= pc, out_valid <= 1.
     - pc <= pc + 4.
  4. Otherwise (stall: out_valid=1, out_ready=0):
     - out_instruction, out_pc and pc hold.
- Throughput and latency:
  - One instruction per cycle when out_ready stays 1.
  - After reset release or a redirect, the first out_valid rises 1 cycle later. For a redirect, it is the cycle after the redirect edge.
- HALT:
  - out_valid=0, pc frozen.
  - halt_req is ignored.
  - redirect_valid=1 -> state <= FETCH, pc <= redirect_target; fetching resumes the following cycle.
- Wrap-around: pc + 4 is computed modulo 2^ADDR_WIDTH. From 0xFFFFFFFC the next PC is 0x00000000, with no flag.
- Alignment (feature off): pc[1:0] is always forced to 0 on every load, including redirect_target.
- Reset mid-stall or mid-redirect: all state returns to reset values immediately.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- Defined:
  - A redirect_target with bits [1:0] != 0 sets misalign_fault=1 (sticky until reset).
  - State <= HALT, out_valid <= 0, pc <= redirect_target unmodified.
  - While misalign_fault=1, further redirects are ignored and the block stays halted.
- Not defined:
  - The misalign_fault port does not exist.
  - Target bits [1:0] are silently cleared.

Test Plan:
- Reset release with RESET_PC=0 and out_ready=1 held; memory returns word 0x1000_0000+addr -> out_pc sequence 0,4,8,...,60 on consecutive cycles; out_instruction matches; out_valid=1 from cycle 1 after release.
- Stall: out_ready=0 for 3 cycles while out_pc=8 -> out_pc/out_instruction hold at 8; imem_address holds at 12; on release out_pc=12 the next cycle, with no skip or duplicate.
- Redirect to 0x40 in the same cycle as an accept of pc 0x10 -> next cycle out_valid=0 and imem_address=0x40; following cycle out_pc=0x40; 0x14 is never presented.
- halt_req at pc=0x20 -> halted=1, out_valid=0, imem_address stays 0x20 for 5 cycles; redirect to 0x100 -> halted=0, out_pc=0x100 two cycles later.
- Wrap: redirect to 0xFFFF_FFF8 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Misalignment: redirect to 0x22 -> without the macro out_pc=0x20; with IFU_MISALIGN_TRAP_EN misalign_fault=1, halted=1, out_valid stays 0, and a later redirect to 0x0 is ignored. Assert rst_n=0 mid-stream -> all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives a combinational-read
// instruction memory and presents each fetched word with its PC to decode
// through a valid/ready handshake. Handles stalls, redirects and halt.
// Optional feature macro: IFU_MISALIGN_TRAP_EN. When defined, a misaligned
// redirect target raises a sticky misalign_fault and halts. When undefined,
// target bits [1:0] are cleared.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDR_WIDTH-1:0]  imem_address,
  input  logic [INSTR_WIDTH-1:0] imem_instruction,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instruction,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  input  logic                   halt_req,
  output logic                   halted
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic                   misalign_fault
`endif
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_BITS = ADDR_WIDTH'(3);

  state_t                   state_reg, state_next;
  logic [ADDR_WIDTH-1:0]    pc_reg, pc_next;
  logic                     valid_reg, valid_next;
  logic [INSTR_WIDTH-1:0]   instr_reg, instr_next;
  logic [ADDR_WIDTH-1:0]    opc_reg, opc_next;
  logic [ADDR_WIDTH-1:0]    target_pc;
  logic                     target_bad;
  logic                     fault_reg;

`ifdef IFU_MISALIGN_TRAP_EN
  logic fault_next;

  // Target is taken verbatim; any low bit set is a fault.
  assign target_pc  = redirect_target;
  assign target_bad = |(redirect_target & ALIGN_BITS);
`else
  // Target low bits are silently cleared, so the PC stays word-aligned.
  assign target_pc  = redirect_target & ~ALIGN_BITS;
  assign target_bad = 1'b0;
  assign fault_reg  = 1'b0;
`endif

  // State register: everything returns to reset values as soon as rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      pc_reg    <= RESET_PC;
      valid_reg <= 1'b0;
      instr_reg <= '0;
      opc_reg   <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      valid_reg <= valid_next;
      instr_reg <= instr_next;
      opc_reg   <= opc_next;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_reg <= fault_next;
`endif
    end
  end

  // Next-state logic: redirect beats halt, which beats load; otherwise stall.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    valid_next = valid_reg;
    instr_next = instr_reg;
    opc_next   = opc_reg;
`ifdef IFU_MISALIGN_TRAP_EN
    fault_next = fault_reg;
`endif
    case (state_reg)
      S_FETCH: begin
        if (redirect_valid) begin
          // Flush even if decode accepted this cycle; it consumed the old word.
          valid_next = 1'b0;
          pc_next    = target_pc;
          if (target_bad) begin
            state_next = S_HALT;
`ifdef IFU_MISALIGN_TRAP_EN
            fault_next = 1'b1;
`endif
          end
        end else if (halt_req) begin
          // pc already points at the next unfetched word, so it is left alone.
          state_next = S_HALT;
          valid_next = 1'b0;
        end else if (!valid_reg || out_ready) begin
          instr_next = imem_instruction;
          opc_next   = pc_reg;
          valid_next = 1'b1;
          pc_next    = pc_reg + PC_STEP;
        end
      end
      S_HALT: begin
        valid_next = 1'b0;
        // A faulted unit ignores redirects until reset.
        if (redirect_valid && !fault_reg) begin
          pc_next = target_pc;
          if (target_bad) begin
`ifdef IFU_MISALIGN_TRAP_EN
            fault_next = 1'b1;
`endif
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign imem_address    = pc_reg;
  assign out_valid       = valid_reg;
  assign out_instruction = instr_reg;
  assign out_pc          = opc_reg;
  assign halted          = (state_reg == S_HALT);
`ifdef IFU_MISALIGN_TRAP_EN
  assign misalign_fault  = fault_reg;
`endif

endmodule
